// File: rtl/fu_sched.sv
// fu_sched: issue scheduler for two reservation-station slots sharing
// two ALUs, two non-pipelined multipliers and one memory port.
// Grants are combinational from the current state and requests. Unit
// state advances on the edge that samples those grants.
// Optional macro FU_SCHED_RR_EN: when defined, a round-robin pointer
// decides multiply/memory contention. When undefined, slot0 always wins.
module fu_sched #(
  parameter int MULT_LAT = 4,
  parameter int NUM_SLOT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SLOT-1:0] alu_req,
  input  logic [NUM_SLOT-1:0] mult_req,
  input  logic [NUM_SLOT-1:0] mem_req,
  input  logic                mem_done,
  input  logic                flush,
  output logic [NUM_SLOT-1:0] exfu_free,
  output logic [NUM_SLOT-1:0] multfu_free,
  output logic [NUM_SLOT-1:0] memfu_free,
  output logic [NUM_SLOT-1:0] mult_unit,
  output logic [NUM_SLOT-1:0] mult_done
);

  // The grant cycle counts as the first occupied cycle, so the counter
  // register holds MULT_LAT-2 on the cycle after the grant.
  localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT - 2);

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  mem_state_t       mem_state_q, mem_state_d;
  logic [1:0]       mul_busy_q, mul_busy_d;
  logic [1:0][3:0]  mul_cnt_q, mul_cnt_d;

  logic             grant_en;
  logic             pri_slot;
  logic [1:0]       mult_idle;
  logic [1:0]       mult_req_en;
  logic [1:0]       mult_g;
  logic [1:0]       unit_sel;
  logic [1:0]       unit_start;
  logic [1:0]       mem_cand;
  logic [1:0]       mem_g;
  logic [1:0]       alu_g;
  logic [1:0]       mult_done_c;

  assign grant_en    = !reset && !flush;
  assign mult_idle   = ~mul_busy_q;
  assign mult_req_en = mult_req & {2{grant_en}};

`ifdef FU_SCHED_RR_EN
  logic ptr_q, ptr_d;
  logic contended;

  assign pri_slot = ptr_q;

  // A contended grant hands priority to the slot that lost this cycle.
  always_comb begin
    contended = ((mult_req_en == 2'b11) && (^mult_g)) || (mem_cand == 2'b11);
    ptr_d     = ptr_q ^ contended;
  end

  // Priority pointer register; flush produces no grants, so it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pri_slot = 1'b0;
`endif

  // Multiplier arbitration: idle units are handed out in slot order. A
  // single idle unit with two requesters goes to the priority slot.
  always_comb begin
    mult_g   = '0;
    unit_sel = '0;
    case (mult_idle)
      2'b11: begin
        mult_g      = mult_req_en;
        unit_sel[1] = mult_req_en[0];
      end
      2'b01, 2'b10: begin
        if (mult_req_en == 2'b11) begin
          mult_g[pri_slot]   = 1'b1;
          unit_sel[pri_slot] = mult_idle[1];
        end else begin
          mult_g   = mult_req_en;
          unit_sel = mult_req_en & {2{mult_idle[1]}};
        end
      end
      default: begin
        mult_g   = '0;
        unit_sel = '0;
      end
    endcase
  end

  // Memory and ALU grants take whatever the multiplier left unserved.
  always_comb begin
    mem_cand = mem_req & ~mult_g & {2{grant_en && (mem_state_q == MEM_IDLE)}};
    mem_g    = '0;
    if (mem_cand == 2'b11) begin
      mem_g[pri_slot] = 1'b1;
    end else begin
      mem_g = mem_cand;
    end
    alu_g = alu_req & ~mult_g & ~mem_g & {2{grant_en}};
  end

  // Map slot grants onto the multiplier units they start.
  always_comb begin
    unit_start = '0;
    for (int s = 0; s < 2; s++) begin
      if (mult_g[s]) begin
        unit_start[unit_sel[s]] = 1'b1;
      end
    end
  end

  // Multiplier occupancy counters. Expiry pulses done and frees the unit
  // one cycle later. Flush clears everything without a pulse.
  always_comb begin
    mul_busy_d  = mul_busy_q;
    mul_cnt_d   = mul_cnt_q;
    mult_done_c = '0;
    for (int i = 0; i < 2; i++) begin
      if (mul_busy_q[i]) begin
        if (mul_cnt_q[i] == 4'd0) begin
          mul_busy_d[i]  = 1'b0;
          mult_done_c[i] = grant_en;
        end else begin
          mul_cnt_d[i] = mul_cnt_q[i] - 4'd1;
        end
      end
      if (unit_start[i]) begin
        mul_busy_d[i] = 1'b1;
        mul_cnt_d[i]  = CNT_LOAD;
      end
    end
    if (flush) begin
      mul_busy_d = '0;
      mul_cnt_d  = '0;
    end
  end

  // Memory port FSM. A completion that arrives while the port is idle
  // is ignored.
  always_comb begin
    mem_state_d = mem_state_q;
    case (mem_state_q)
      MEM_IDLE: if (|mem_g)   mem_state_d = MEM_BUSY;
      MEM_BUSY: if (mem_done) mem_state_d = MEM_IDLE;
      default:                mem_state_d = MEM_IDLE;
    endcase
    if (flush) begin
      mem_state_d = MEM_IDLE;
    end
  end

  // State registers. Reset drops any in-flight work outright.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_state_q <= MEM_IDLE;
      mul_busy_q  <= '0;
      mul_cnt_q   <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      mul_busy_q  <= mul_busy_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  assign exfu_free   = alu_g;
  assign multfu_free = mult_g;
  assign memfu_free  = mem_g;
  assign mult_unit   = unit_sel & mult_g;
  assign mult_done   = mult_done_c;

endmodule
